// File: rtl/ahb_seq_pkg.sv
// Shared definitions for the AHB instruction sequencer: field positions, FSM state codes
// and the register-usage decode helpers.
package ahb_seq_pkg;

    localparam int unsigned InstW    = 64;

    localparam int unsigned BitHwrite = 0;
    localparam int unsigned BurstLo   = 1;
    localparam int unsigned SizeLo    = 4;
    localparam int unsigned BitWork   = 7;
    localparam int unsigned BlenLo    = 8;
    localparam int unsigned BitReg    = 18;
    localparam int unsigned Rr1Lo     = 19;
    localparam int unsigned Rr2Lo     = 22;
    localparam int unsigned WrLo      = 25;
    localparam int unsigned AluLo     = 28;
    localparam int unsigned BitRw     = 31;
    localparam int unsigned AddrLo    = 32;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StStall = 2'd2;

    function automatic logic writes_reg(input logic rw, input logic rsel);
        return rw == rsel;
    endfunction

    function automatic logic reads_rr1(input logic rw, input logic rsel);
        return !(!rw && !rsel);
    endfunction

    function automatic logic reads_rr2(input logic rsel);
        return rsel;
    endfunction

    // True when an instruction with these read fields depends on register wr.
    function automatic logic raw_hazard(input logic rw, input logic rsel, input logic [2:0] rr1,
                                        input logic [2:0] rr2, input logic [2:0] wr);
        return (reads_rr1(rw, rsel) && (rr1 == wr)) || (reads_rr2(rsel) && (rr2 == wr));
    endfunction

    // Bus occupancy in cycles; 9 bits so burst_length 255 yields 257.
    function automatic logic [8:0] beats_init(input logic [2:0] hburst, input logic [7:0] blen);
        if (hburst == 3'd0) begin
            return 9'd2;
        end
        return {1'b0, blen} + 9'd2;
    endfunction

endpackage

// File: rtl/ahb_seq_fifo.sv
// Synchronous FIFO with registered occupancy count; full/empty decode from the count.
module ahb_seq_fifo #(
    parameter int unsigned Depth = 4,
    parameter int unsigned Width = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [Width-1:0]         data_i,
    input  logic                     pop_i,
    output logic [Width-1:0]         data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(Depth):0]   count_o
);

    localparam int unsigned AW = $clog2(Depth);
    localparam logic [AW:0] FullCount = Depth[AW:0];

    logic [Width-1:0] mem_q [Depth];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == FullCount);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];

    // A push into a full FIFO is refused even if a pop frees a slot this cycle.
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            count_q <= count_d;
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/ahb_inst_sequencer.sv
// Issues buffered 64-bit instructions to the AHB master one at a time, holding each for its
// bus occupancy. Define AHB_SEQ_RAW_STALL_EN to stall only on a true register RAW hazard.
module ahb_inst_sequencer
    import ahb_seq_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                    HCLK,
    input  logic                    HRESETn,
    input  logic                    inst_valid,
    input  logic [63:0]             inst_data,
    output logic                    inst_ready,
    input  logic                    HREADY,
    input  logic                    HRESP,
    output logic [63:0]             cpu_inst,
    output logic                    busy,
    output logic                    err,
    input  logic                    err_clr,
    output logic [$clog2(DEPTH):0]  count
);

    logic [1:0]       state_q, state_d;
    logic [InstW-1:0] cur_q, cur_d;
    logic [8:0]       beats_q, beats_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic             last_we_q, last_we_d;

    logic [InstW-1:0] head;
    logic             full, empty, pop;
    logic             idle_hazard, stall_after;

    ahb_seq_fifo #(
        .Depth (DEPTH),
        .Width (InstW)
    ) u_fifo (
        .clk_i   (HCLK),
        .rst_ni  (HRESETn),
        .push_i  (inst_valid),
        .data_i  (inst_data),
        .pop_i   (pop),
        .data_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    assign inst_ready = !full;
    assign cpu_inst   = cur_q;
    assign busy       = busy_q;
    assign err        = err_q;

`ifdef AHB_SEQ_RAW_STALL_EN
    logic [2:0] last_wr_q, last_wr_d;

    assign idle_hazard = last_we_q &&
        raw_hazard(head[BitRw], head[BitReg], head[Rr1Lo +: 3], head[Rr2Lo +: 3], last_wr_q);
    // Look ahead at the queued head when the writer retires so the bubble costs one cycle.
    assign stall_after = writes_reg(cur_q[BitRw], cur_q[BitReg]) && !empty && head[BitWork] &&
        raw_hazard(head[BitRw], head[BitReg], head[Rr1Lo +: 3], head[Rr2Lo +: 3],
                   cur_q[WrLo +: 3]);
`else
    assign idle_hazard = last_we_q;
    assign stall_after = writes_reg(cur_q[BitRw], cur_q[BitReg]);
`endif

    always_comb begin
        state_d   = state_q;
        cur_d     = cur_q;
        beats_d   = beats_q;
        busy_d    = busy_q;
        last_we_d = last_we_q;
        err_d     = err_q && !err_clr;
        pop       = 1'b0;
`ifdef AHB_SEQ_RAW_STALL_EN
        last_wr_d = last_wr_q;
`endif
        case (state_q)
            StIdle: begin
                if (!empty) begin
                    if (!head[BitWork]) begin
                        pop = 1'b1;
                    end else if (idle_hazard) begin
                        state_d = StStall;
                    end else begin
                        pop     = 1'b1;
                        cur_d   = head;
                        beats_d = beats_init(head[BurstLo +: 3], head[BlenLo +: 8]);
                        busy_d  = 1'b1;
                        state_d = StIssue;
                    end
                end
            end
            StIssue: begin
                if (HRESP) begin
                    err_d     = 1'b1;
                    cur_d     = '0;
                    busy_d    = 1'b0;
                    last_we_d = 1'b0;
                    state_d   = StIdle;
                end else if (HREADY) begin
                    if (beats_q == 9'd1) begin
                        cur_d     = '0;
                        busy_d    = 1'b0;
                        last_we_d = writes_reg(cur_q[BitRw], cur_q[BitReg]);
`ifdef AHB_SEQ_RAW_STALL_EN
                        last_wr_d = cur_q[WrLo +: 3];
`endif
                        state_d   = stall_after ? StStall : StIdle;
                    end else begin
                        beats_d = beats_q - 9'd1;
                    end
                end
            end
            StStall: begin
                last_we_d = 1'b0;
                state_d   = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q   <= StIdle;
            cur_q     <= '0;
            beats_q   <= '0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
            last_we_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            beats_q   <= beats_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
            last_we_q <= last_we_d;
        end
    end

`ifdef AHB_SEQ_RAW_STALL_EN
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            last_wr_q <= '0;
        end else begin
            last_wr_q <= last_wr_d;
        end
    end
`endif

endmodule

// File: tb/tb_ahb_inst_sequencer.sv
// Directed self-checking bench for ahb_inst_sequencer; expectations follow the build's
// AHB_SEQ_RAW_STALL_EN setting.
module tb_ahb_inst_sequencer;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        inst_valid;
    logic [63:0] inst_data;
    logic        inst_ready;
    logic        HREADY;
    logic        HRESP;
    logic [63:0] cpu_inst;
    logic        busy;
    logic        err;
    logic        err_clr;
    logic [2:0]  count;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] tr [0:19];

    ahb_inst_sequencer #(
        .DEPTH (4)
    ) dut (
        .HCLK       (HCLK),
        .HRESETn    (HRESETn),
        .inst_valid (inst_valid),
        .inst_data  (inst_data),
        .inst_ready (inst_ready),
        .HREADY     (HREADY),
        .HRESP      (HRESP),
        .cpu_inst   (cpu_inst),
        .busy       (busy),
        .err        (err),
        .err_clr    (err_clr),
        .count      (count)
    );

    always #5 HCLK = ~HCLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    function automatic logic [63:0] mk(input logic work, input logic [2:0] hburst,
                                       input logic [7:0] blen, input logic rsel,
                                       input logic [2:0] rr1, input logic [2:0] rr2,
                                       input logic [2:0] wr, input logic rw,
                                       input logic [31:0] addr);
        logic [63:0] v;
        v        = '0;
        v[0]     = 1'b1;
        v[3:1]   = hburst;
        v[6:4]   = 3'd2;
        v[7]     = work;
        v[15:8]  = blen;
        v[18]    = rsel;
        v[21:19] = rr1;
        v[24:22] = rr2;
        v[27:25] = wr;
        v[31]    = rw;
        v[63:32] = addr;
        return v;
    endfunction

    task automatic step();
        @(negedge HCLK);
    endtask

    task automatic capture(input int n);
        for (int i = 0; i < n; i++) begin
            tr[i] = cpu_inst;
            step();
        end
    endtask

    task automatic test_reset();
        HRESETn = 1'b0; inst_valid = 1'b0; inst_data = '0;
        HREADY = 1'b1; HRESP = 1'b0; err_clr = 1'b0;
        step(); step();
        n_checks++; if (cpu_inst !== 64'd0) begin n_fail++; $display("FAIL reset_cpu_inst got %h want 0", cpu_inst); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err got %b want 0", err); end
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
        n_checks++; if (inst_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready got %b want 1", inst_ready); end
        HRESETn = 1'b1;
        step();
    endtask

    task automatic test_single();
        // Register-writing read; HBURST=0 with a nonzero burst_length still takes 2 beats.
        logic [63:0] a;
        a = mk(1'b1, 3'd0, 8'd7, 1'b0, 3'd0, 3'd0, 3'd0, 1'b0, 32'h1000_0000);
        inst_valid = 1'b1; inst_data = a;
        step();
        inst_valid = 1'b0;
        n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL single_count_push got %0d want 1", count); end
        n_checks++; if (cpu_inst !== 64'd0) begin n_fail++; $display("FAIL single_latency got %h want 0", cpu_inst); end
        step();
        n_checks++; if (cpu_inst !== a) begin n_fail++; $display("FAIL single_load got %h want %h", cpu_inst, a); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy1 got %b want 1", busy); end
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL single_count_pop got %0d want 0", count); end
        step();
        n_checks++; if (cpu_inst !== a) begin n_fail++; $display("FAIL single_hold got %h want %h", cpu_inst, a); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy2 got %b want 1", busy); end
        step();
        n_checks++; if (cpu_inst !== 64'd0) begin n_fail++; $display("FAIL single_end got %h want 0", cpu_inst); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_busy_end got %b want 0", busy); end
        step(); step();
    endtask

    task automatic test_hazard_pair(input logic [63:0] s, input logic [63:0] t,
                                    input logic stall);
        logic [63:0] exp [0:6];
        int k;
        inst_valid = 1'b1; inst_data = s;
        step();
        inst_data = t;
        step();
        inst_valid = 1'b0;
        capture(7);
        k = 0;
        exp[k] = s; k++; exp[k] = s; k++; exp[k] = '0; k++;
        if (stall) begin exp[k] = '0; k++; end
        exp[k] = t; k++; exp[k] = t; k++; exp[k] = '0; k++;
        if (!stall) begin exp[k] = '0; k++; end
        for (int i = 0; i < 7; i++) begin
            n_checks++;
            if (tr[i] !== exp[i]) begin
                n_fail++;
                $display("FAIL hazard_trace[%0d] stall=%b got %h want %h", i, stall, tr[i], exp[i]);
            end
        end
        step(); step(); step();
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL hazard_drain_count got %0d want 0", count); end
    endtask

    task automatic test_hazard();
        logic [63:0] s, t1, t2;
        logic raw_mode;
`ifdef AHB_SEQ_RAW_STALL_EN
        raw_mode = 1'b1;
`else
        raw_mode = 1'b0;
`endif
        s  = mk(1'b1, 3'd0, 8'd0, 1'b0, 3'd0, 3'd0, 3'd1, 1'b0, 32'h2000_0000);
        t1 = mk(1'b1, 3'd0, 8'd0, 1'b1, 3'd0, 3'd1, 3'd2, 1'b1, 32'h2000_0004);
        t2 = mk(1'b1, 3'd0, 8'd0, 1'b1, 3'd0, 3'd3, 3'd2, 1'b1, 32'h2000_0008);
        test_hazard_pair(s, t1, 1'b1);
        // No register overlap: only the unconditional build still inserts the bubble.
        test_hazard_pair(s, t2, !raw_mode);
    endtask

    task automatic test_burst();
        logic [63:0] b;
        logic        hr [0:9];
        b = mk(1'b1, 3'd1, 8'd3, 1'b0, 3'd4, 3'd0, 3'd0, 1'b1, 32'h3000_0000);
        for (int i = 0; i < 10; i++) hr[i] = 1'b1;
        hr[2] = 1'b0; hr[3] = 1'b0;
        inst_valid = 1'b1; inst_data = b;
        step();
        inst_valid = 1'b0;
        step();
        for (int i = 0; i < 10; i++) begin
            HREADY = hr[i];
            n_checks++;
            if (cpu_inst !== ((i < 7) ? b : 64'd0)) begin
                n_fail++;
                $display("FAIL burst_hold[%0d] got %h want %h", i, cpu_inst, (i < 7) ? b : 64'd0);
            end
            step();
        end
        HREADY = 1'b1;
    endtask

    task automatic test_long_burst();
        logic [63:0] l;
        int held;
        l = mk(1'b1, 3'd3, 8'd255, 1'b0, 3'd5, 3'd0, 3'd0, 1'b1, 32'h3100_0000);
        inst_valid = 1'b1; inst_data = l;
        step();
        inst_valid = 1'b0;
        held = 0;
        for (int i = 0; i < 270; i++) begin
            step();
            if (cpu_inst === l) held++;
        end
        n_checks++; if (held !== 257) begin n_fail++; $display("FAIL long_burst_cycles got %0d want 257", held); end
    endtask

    task automatic test_error();
        logic [63:0] a, b, c;
        a = mk(1'b1, 3'd0, 8'd0, 1'b0, 3'd1, 3'd0, 3'd0, 1'b1, 32'h4000_0000);
        b = mk(1'b1, 3'd0, 8'd0, 1'b0, 3'd1, 3'd0, 3'd0, 1'b1, 32'h4000_0004);
        c = mk(1'b1, 3'd0, 8'd0, 1'b0, 3'd1, 3'd0, 3'd0, 1'b1, 32'h4000_0008);
        inst_valid = 1'b1; inst_data = a;
        step();
        inst_data = b;
        step();
        inst_valid = 1'b0;
        HRESP = 1'b1;
        n_checks++; if (cpu_inst !== a) begin n_fail++; $display("FAIL err_issue got %h want %h", cpu_inst, a); end
        n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL err_count_before got %0d want 1", count); end
        step();
        HRESP = 1'b0;
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_set got %b want 1", err); end
        n_checks++; if (cpu_inst !== 64'd0) begin n_fail++; $display("FAIL err_abort got %h want 0", cpu_inst); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL err_busy got %b want 0", busy); end
        step();
        n_checks++; if (cpu_inst !== b) begin n_fail++; $display("FAIL err_next got %h want %h", cpu_inst, b); end
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL err_count_after got %0d want 0", count); end
        step(); step();
        n_checks++; if (cpu_inst !== 64'd0) begin n_fail++; $display("FAIL err_next_end got %h want 0", cpu_inst); end
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_sticky got %b want 1", err); end
        // Error and clear in the same cycle: error wins.
        inst_valid = 1'b1; inst_data = c;
        step();
        inst_valid = 1'b0;
        step();
        HRESP = 1'b1; err_clr = 1'b1;
        step();
        HRESP = 1'b0; err_clr = 1'b0;
        n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL err_clr_collide got %b want 1", err); end
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL err_clear got %b want 0", err); end
    endtask

    task automatic test_full();
        logic [63:0] ins [0:4];
        logic [63:0] junk;
        logic [63:0] exp [0:15];
        for (int i = 0; i < 5; i++) begin
            ins[i] = mk(1'b1, 3'd0, 8'd0, 1'b0, 3'd2, 3'd0, 3'd0, 1'b1, 32'h5000_0000 + i);
        end
        junk = mk(1'b1, 3'd0, 8'd0, 1'b0, 3'd2, 3'd0, 3'd0, 1'b1, 32'hDEAD_BEEF);
        inst_valid = 1'b1; inst_data = ins[0];
        step();
        inst_data = ins[1];
        step();
        HREADY = 1'b0;
        for (int i = 2; i < 5; i++) begin
            inst_data = ins[i];
            step();
        end
        n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_count got %0d want 4", count); end
        n_checks++; if (inst_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready got %b want 0", inst_ready); end
        n_checks++; if (cpu_inst !== ins[0]) begin n_fail++; $display("FAIL full_holding got %h want %h", cpu_inst, ins[0]); end
        inst_data = junk;
        step(); step();
        n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_no_push got %0d want 4", count); end
        inst_valid = 1'b0; HREADY = 1'b1;
        capture(16);
        for (int i = 0; i < 5; i++) begin
            exp[3*i] = ins[i]; exp[3*i+1] = ins[i]; exp[3*i+2] = '0;
        end
        exp[15] = '0;
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if (tr[i] !== exp[i]) begin
                n_fail++;
                $display("FAIL full_order[%0d] got %h want %h", i, tr[i], exp[i]);
            end
        end
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL full_drain got %0d want 0", count); end
        n_checks++; if (inst_ready !== 1'b1) begin n_fail++; $display("FAIL full_ready_back got %b want 1", inst_ready); end
    endtask

    task automatic test_work_zero();
        logic [63:0] w, x;
        logic [63:0] exp [0:4];
        w = mk(1'b0, 3'd0, 8'd0, 1'b0, 3'd1, 3'd0, 3'd0, 1'b1, 32'h6000_0000);
        x = mk(1'b1, 3'd0, 8'd0, 1'b0, 3'd1, 3'd0, 3'd0, 1'b1, 32'h6000_0004);
        inst_valid = 1'b1; inst_data = w;
        step();
        inst_data = x;
        step();
        inst_valid = 1'b0;
        capture(5);
        exp[0] = '0; exp[1] = x; exp[2] = x; exp[3] = '0; exp[4] = '0;
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (tr[i] !== exp[i]) begin
                n_fail++;
                $display("FAIL work_zero[%0d] got %h want %h", i, tr[i], exp[i]);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        logic [63:0] r1, r2;
        r1 = mk(1'b1, 3'd1, 8'd10, 1'b0, 3'd3, 3'd0, 3'd0, 1'b1, 32'h7000_0000);
        r2 = mk(1'b1, 3'd0, 8'd0, 1'b0, 3'd3, 3'd0, 3'd0, 1'b1, 32'h7000_0004);
        inst_valid = 1'b1; inst_data = r1;
        step();
        inst_data = r2;
        step();
        inst_valid = 1'b0;
        step(); step();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rst_pre_busy got %b want 1", busy); end
        #2;
        HRESETn = 1'b0;
        #1;
        n_checks++; if (cpu_inst !== 64'd0) begin n_fail++; $display("FAIL rst_async_cpu got %h want 0", cpu_inst); end
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL rst_async_count got %0d want 0", count); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_async_busy got %b want 0", busy); end
        step();
        HRESETn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (cpu_inst !== 64'd0) begin
                n_fail++;
                $display("FAIL rst_discard[%0d] got %h want 0", i, cpu_inst);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_hazard();
        test_burst();
        test_long_burst();
        test_error();
        test_full();
        test_work_zero();
        test_reset_mid_burst();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
